// File: rtl/multi_bank_bram_pipe_if.sv
// ---------------------------------------------------------------------------
// multi_bank_bram_pipe_if
// Bundles the per-bank port A / port B buses and the clear-engine controls of
// multi_bank_bram_pipe. All multi-bank vectors are flattened with bank i at
// [i*W +: W].
//   master : the user side (coefficient loaders / spline evaluators / bench)
//   slave  : the memory
// Signals:
//   ena/wea/addra/dina  port A enable, byte write enables, address, write data
//   bcast               apply bank-0 port A write to all banks
//   douta/valida        port A read-first data and its qualifier
//   enb/addrb           port B read enable and address
//   doutb/validb        port B read data and its qualifier
//   clear_req           one-cycle request to zero the whole memory
//   init_busy           clear engine active
// ---------------------------------------------------------------------------
interface multi_bank_bram_pipe_if #(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int ADDR  = 8,
  parameter int WE    = WIDTH / 8
);
  logic [BANKS-1:0]       ena;
  logic [BANKS*WE-1:0]    wea;
  logic [BANKS*ADDR-1:0]  addra;
  logic [BANKS*WIDTH-1:0] dina;
  logic                   bcast;
  logic [BANKS*WIDTH-1:0] douta;
  logic [BANKS-1:0]       valida;
  logic [BANKS-1:0]       enb;
  logic [BANKS*ADDR-1:0]  addrb;
  logic [BANKS*WIDTH-1:0] doutb;
  logic [BANKS-1:0]       validb;
  logic                   clear_req;
  logic                   init_busy;

  modport master (
    output ena, wea, addra, dina, bcast, enb, addrb, clear_req,
    input  douta, valida, doutb, validb, init_busy
  );

  modport slave (
    input  ena, wea, addra, dina, bcast, enb, addrb, clear_req,
    output douta, valida, doutb, validb, init_busy
  );
endinterface

// File: rtl/multi_bank_bram_pipe.sv
// ---------------------------------------------------------------------------
// multi_bank_bram_pipe
// Banked true-dual-port memory: BANKS independent banks, each with a
// byte-enabled read-first write/read port A and a read-only port B, a
// READ_LATENCY-deep read pipeline with per-bank valids, broadcast writes,
// a configurable same-address collision policy and a clear engine.
// Ports:
//   clk          clock
//   rstn         synchronous active-low reset
//   bus          multi_bank_bram_pipe_if.slave (port A, port B, clear control)
//   o_dbg_state  clear-engine FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake: there is no back-pressure. A request is accepted in every cycle
// its enable is high while the clear engine is idle; exactly READ_LATENCY
// cycles later the matching valid bit is high for one cycle with the data.
// Data outputs hold their last matured value while valid is low.
// ---------------------------------------------------------------------------
module multi_bank_bram_pipe #(
  parameter int BANKS          = 4,
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 256,
  parameter int ADDR           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WE             = WIDTH / 8,
  parameter int READ_LATENCY   = 2,
  parameter int COLLISION_FWD  = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  multi_bank_bram_pipe_if.slave     bus,
  output logic [0:0]                o_dbg_state
);

  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_CLEAR   = 1'b1;
  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR:0]   DEPTH_W   = DEPTH[ADDR:0];
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [BANKS][DEPTH];

  logic [0:0]      r_state;
  logic [ADDR-1:0] r_cnt;

  logic [BANKS-1:0] r_va [READ_LATENCY];
  logic [BANKS-1:0] r_vb [READ_LATENCY];
  logic [WIDTH-1:0] r_da [READ_LATENCY][BANKS];
  logic [WIDTH-1:0] r_db [READ_LATENCY][BANKS];

  logic             w_busy;
  logic             w_bc;
  logic [BANKS-1:0] w_wr_en;
  logic [BANKS-1:0] w_rda;
  logic [BANKS-1:0] w_rdb;
  logic [BANKS-1:0] w_a_inr;
  logic [BANKS-1:0] w_b_inr;
  logic [WE-1:0]    w_we     [BANKS];
  logic [ADDR-1:0]  w_addr_a [BANKS];
  logic [ADDR-1:0]  w_addr_b [BANKS];
  logic [WIDTH-1:0] w_din    [BANKS];
  logic [WIDTH-1:0] w_rd_a   [BANKS];
  logic [WIDTH-1:0] w_rd_b   [BANKS];

  assign w_busy      = (r_state == S_CLEAR);
  assign w_bc        = !w_busy && bus.bcast && bus.ena[0];
  assign o_dbg_state = r_state;
  assign bus.init_busy = w_busy;

  // Effective per-bank controls. During a broadcast every bank takes bank 0's
  // write fields, but only bank 0 returns a port A read.
  always_comb begin
    int src;
    src = 0;
    for (int i = 0; i < BANKS; i++) begin
      src         = w_bc ? 0 : i;
      w_we[i]     = bus.wea[src*WE +: WE];
      w_addr_a[i] = bus.addra[src*ADDR +: ADDR];
      w_din[i]    = bus.dina[src*WIDTH +: WIDTH];
      w_addr_b[i] = bus.addrb[i*ADDR +: ADDR];
      w_wr_en[i]  = !w_busy && (w_bc || bus.ena[i]);
      w_rda[i]    = !w_busy && bus.ena[i] && (!w_bc || (i == 0));
      w_rdb[i]    = !w_busy && bus.enb[i];
      w_a_inr[i]  = ({1'b0, w_addr_a[i]} < DEPTH_W);
      w_b_inr[i]  = ({1'b0, w_addr_b[i]} < DEPTH_W);
      // Port A is read-first: the array still holds pre-write data here.
      w_rd_a[i]   = w_a_inr[i] ? r_mem[i][w_addr_a[i]] : '0;
      w_rd_b[i]   = w_b_inr[i] ? r_mem[i][w_addr_b[i]] : '0;
      // Same-bank, same-address collision: merge the bytes being written.
      if ((COLLISION_FWD != 0) && w_wr_en[i] && w_a_inr[i] && w_b_inr[i] &&
          (w_addr_a[i] == w_addr_b[i])) begin
        for (int b = 0; b < WE; b++) begin
          if (w_we[i][b]) w_rd_b[i][b*8 +: 8] = w_din[i][b*8 +: 8];
        end
      end
    end
  end

  // Memory array. Reset does not touch contents; out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < BANKS; i++) begin
        if (w_busy) begin
          r_mem[i][r_cnt] <= '0;
        end else if (w_wr_en[i] && w_a_inr[i]) begin
          for (int b = 0; b < WE; b++) begin
            if (w_we[i][b]) r_mem[i][w_addr_a[i]][b*8 +: 8] <= w_din[i][b*8 +: 8];
          end
        end
      end
    end
  end

  // Clear engine: one address per cycle across all banks, DEPTH cycles total.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clear_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Read pipelines. Data stages only load when a valid moves into them, so
  // the last stage keeps the most recent matured word between requests.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_va[s] <= '0;
        r_vb[s] <= '0;
        for (int i = 0; i < BANKS; i++) begin
          r_da[s][i] <= '0;
          r_db[s][i] <= '0;
        end
      end
    end else begin
      r_va[0] <= w_rda;
      r_vb[0] <= w_rdb;
      for (int i = 0; i < BANKS; i++) begin
        if (w_rda[i]) r_da[0][i] <= w_rd_a[i];
        if (w_rdb[i]) r_db[0][i] <= w_rd_b[i];
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_va[s] <= r_va[s-1];
        r_vb[s] <= r_vb[s-1];
        for (int i = 0; i < BANKS; i++) begin
          if (r_va[s-1][i]) r_da[s][i] <= r_da[s-1][i];
          if (r_vb[s-1][i]) r_db[s][i] <= r_db[s-1][i];
        end
      end
    end
  end

  always_comb begin
    bus.douta  = '0;
    bus.doutb  = '0;
    bus.valida = r_va[READ_LATENCY-1];
    bus.validb = r_vb[READ_LATENCY-1];
    for (int i = 0; i < BANKS; i++) begin
      bus.douta[i*WIDTH +: WIDTH] = r_da[READ_LATENCY-1][i];
      bus.doutb[i*WIDTH +: WIDTH] = r_db[READ_LATENCY-1][i];
    end
  end

endmodule

// File: tb/tb_multi_bank_bram_pipe.sv
// ---------------------------------------------------------------------------
// tb_multi_bank_bram_pipe
// Two instances share one stimulus stream:
//   dut0: DEPTH=256, COLLISION_FWD=1     dut1: DEPTH=200, COLLISION_FWD=0
// A reference model (plain arrays plus per-bank queues of expected results
// tagged with the cycle they are due) checks every output each cycle; a
// vector table and a few hand-written sequences check spec constants.
// ---------------------------------------------------------------------------
module tb_multi_bank_bram_pipe;
  localparam int BANKS = 4;
  localparam int WIDTH = 16;
  localparam int WE    = 2;
  localparam int ADDR  = 8;
  localparam int RL    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // ---------------- shared stimulus ----------------
  logic [BANKS-1:0]       ena;
  logic [BANKS*WE-1:0]    wea;
  logic [BANKS*ADDR-1:0]  addra;
  logic [BANKS*WIDTH-1:0] dina;
  logic                   bcast;
  logic [BANKS-1:0]       enb;
  logic [BANKS*ADDR-1:0]  addrb;
  logic                   clear_req;
  logic [0:0]             st0, st1;

  multi_bank_bram_pipe_if #(.BANKS(BANKS), .WIDTH(WIDTH), .ADDR(ADDR), .WE(WE)) if0 ();
  multi_bank_bram_pipe_if #(.BANKS(BANKS), .WIDTH(WIDTH), .ADDR(ADDR), .WE(WE)) if1 ();

  assign if0.ena = ena;     assign if1.ena = ena;
  assign if0.wea = wea;     assign if1.wea = wea;
  assign if0.addra = addra; assign if1.addra = addra;
  assign if0.dina = dina;   assign if1.dina = dina;
  assign if0.bcast = bcast; assign if1.bcast = bcast;
  assign if0.enb = enb;     assign if1.enb = enb;
  assign if0.addrb = addrb; assign if1.addrb = addrb;
  assign if0.clear_req = clear_req; assign if1.clear_req = clear_req;

  multi_bank_bram_pipe #(.BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(256), .READ_LATENCY(RL),
    .COLLISION_FWD(1), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rstn(rstn), .bus(if0.slave), .o_dbg_state(st0));

  multi_bank_bram_pipe #(.BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(200), .READ_LATENCY(RL),
    .COLLISION_FWD(0), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(if1.slave), .o_dbg_state(st1));

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit model_live = 0;

  int mdl_depth [2] = '{256, 200};
  int mdl_fwd   [2] = '{1, 0};
  logic [15:0] mdl_mem [2][BANKS][256];
  int busy_cnt [2];
  int clr_idx  [2];
  logic [15:0] exp_bq [2][BANKS][$];
  int          due_bq [2][BANKS][$];
  logic [15:0] exp_aq [2][BANKS][$];
  int          due_aq [2][BANKS][$];
  logic [15:0] last_b [2][BANKS];
  logic [15:0] last_a [2][BANKS];

  task automatic cmp(input string name, input int d, input int b,
                     input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d bank%0d cycle %0d: got %h want %h", name, d, b, edge_n, got, want);
    end
  endtask

  function automatic logic [15:0] mdl_read(input int d, input int b, input int a);
    return (a < mdl_depth[d]) ? mdl_mem[d][b][a] : 16'h0000;
  endfunction

  // Apply one rising edge's worth of the spec's rules to model d.
  task automatic model_edge(input int d);
    bit          bc, wen;
    int          src, wa, ra;
    logic [1:0]  wm;
    logic [15:0] wd, v;
    if (!rstn) begin
      busy_cnt[d] = mdl_depth[d];
      clr_idx[d]  = 0;
      for (int b = 0; b < BANKS; b++) begin
        exp_bq[d][b].delete(); due_bq[d][b].delete();
        exp_aq[d][b].delete(); due_aq[d][b].delete();
        last_b[d][b] = 16'h0; last_a[d][b] = 16'h0;
      end
      return;
    end
    if (busy_cnt[d] > 0) begin
      for (int b = 0; b < BANKS; b++) mdl_mem[d][b][clr_idx[d]] = 16'h0;
      clr_idx[d]++;
      busy_cnt[d]--;
      return;
    end
    bc = bcast && ena[0];
    for (int pass = 0; pass < 2; pass++) begin
      for (int b = 0; b < BANKS; b++) begin
        src = bc ? 0 : b;
        wen = bc || ena[b];
        wa  = int'(addra[src*ADDR +: ADDR]);
        wm  = wea[src*WE +: WE];
        wd  = dina[src*WIDTH +: WIDTH];
        if (pass == 0) begin
          if (enb[b]) begin
            ra = int'(addrb[b*ADDR +: ADDR]);
            v  = mdl_read(d, b, ra);
            if (mdl_fwd[d] == 1 && wen && ra == wa && ra < mdl_depth[d])
              for (int k = 0; k < WE; k++) if (wm[k]) v[k*8 +: 8] = wd[k*8 +: 8];
            exp_bq[d][b].push_back(v);
            due_bq[d][b].push_back(edge_n + RL - 1);
          end
          if (ena[b] && (!bc || b == 0)) begin
            exp_aq[d][b].push_back(mdl_read(d, b, wa));
            due_aq[d][b].push_back(edge_n + RL - 1);
          end
        end else if (wen && wa < mdl_depth[d]) begin
          for (int k = 0; k < WE; k++)
            if (wm[k]) mdl_mem[d][b][wa][k*8 +: 8] = wd[k*8 +: 8];
        end
      end
    end
    if (clear_req) begin
      busy_cnt[d] = mdl_depth[d];
      clr_idx[d]  = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] va, input logic [3:0] vb,
                           input logic [63:0] da, input logic [63:0] db, input logic busy);
    bit ev;
    for (int b = 0; b < BANKS; b++) begin
      ev = (due_bq[d][b].size() > 0) && (due_bq[d][b][0] == edge_n);
      if (ev) begin
        last_b[d][b] = exp_bq[d][b].pop_front();
        void'(due_bq[d][b].pop_front());
      end
      cmp("validb", d, b, {15'h0, vb[b]}, {15'h0, ev});
      cmp("doutb", d, b, db[b*16 +: 16], last_b[d][b]);
      ev = (due_aq[d][b].size() > 0) && (due_aq[d][b][0] == edge_n);
      if (ev) begin
        last_a[d][b] = exp_aq[d][b].pop_front();
        void'(due_aq[d][b].pop_front());
      end
      cmp("valida", d, b, {15'h0, va[b]}, {15'h0, ev});
      cmp("douta", d, b, da[b*16 +: 16], last_a[d][b]);
    end
    cmp("init_busy", d, 0, {15'h0, busy}, {15'h0, busy_cnt[d] > 0});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    ena = '0; wea = '0; addra = '0; dina = '0; bcast = 1'b0;
    enb = '0; addrb = '0; clear_req = 1'b0;
  endtask

  task automatic set_a(input int b, input int a, input logic [15:0] d, input logic [1:0] w);
    ena[b] = 1'b1;
    addra[b*ADDR +: ADDR] = a[7:0];
    dina[b*WIDTH +: WIDTH] = d;
    wea[b*WE +: WE] = w;
  endtask

  task automatic set_b(input int b, input int a);
    enb[b] = 1'b1;
    addrb[b*ADDR +: ADDR] = a[7:0];
  endtask

  // One clock: model sees the same inputs the DUTs sample, outputs are
  // compared 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    edge_n++;
    model_edge(0);
    model_edge(1);
    if (!rstn) model_live = 1;
    #1;
    if (model_live) begin
      check_dut(0, if0.valida, if0.validb, if0.douta, if0.doutb, if0.init_busy);
      check_dut(1, if1.valida, if1.validb, if1.douta, if1.doutb, if1.init_busy);
    end
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(190, 255)) : int'($urandom_range(0, 15));
  endfunction

  // ---------------- vector table ----------------
  localparam int K_WR = 0, K_RD = 1, K_COL = 2, K_BC = 3, K_RDALL = 4;
  typedef struct {
    int          kind;
    int          bank;
    int          addr;
    logic [15:0] data;
    logic [1:0]  we;
    int          aux_addr;   // bank 3 address during broadcast
    logic [15:0] aux_data;   // bank 3 data during broadcast
    logic [15:0] exp0;       // expected doutb, DEPTH=256 / forwarding
    logic [15:0] exp1;       // expected doutb, DEPTH=200 / old data
  } vec_t;
  localparam int NV = 15;
  vec_t tbl [NV];

  int n0, n1, p0, p1, other, first_p, last_p, guard;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < BANKS; b++) begin
        for (int a = 0; a < 256; a++) mdl_mem[d][b][a] = 16'h0;
        last_a[d][b] = 16'h0; last_b[d][b] = 16'h0;
      end
    busy_cnt = '{0, 0};
    clr_idx  = '{0, 0};

    tbl[0]  = '{K_RDALL, 0, 8'h00, 16'h0000, 2'b00, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[1]  = '{K_RDALL, 0, 8'hFF, 16'h0000, 2'b00, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[2]  = '{K_WR,    2, 8'h10, 16'hBEEF, 2'b11, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[3]  = '{K_WR,    2, 8'h10, 16'h1234, 2'b01, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[4]  = '{K_RD,    2, 8'h10, 16'h0000, 2'b00, 0, 16'h0, 16'hBE34, 16'hBE34};
    tbl[5]  = '{K_WR,    1, 8'h20, 16'h1111, 2'b11, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[6]  = '{K_COL,   1, 8'h20, 16'hAAAA, 2'b10, 0, 16'h0, 16'hAA11, 16'h1111};
    tbl[7]  = '{K_RD,    1, 8'h20, 16'h0000, 2'b00, 0, 16'h0, 16'hAA11, 16'hAA11};
    tbl[8]  = '{K_BC,    0, 8'h05, 16'h5A5A, 2'b11, 8'h07, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[9]  = '{K_RDALL, 0, 8'h05, 16'h0000, 2'b00, 0, 16'h0, 16'h5A5A, 16'h5A5A};
    tbl[10] = '{K_RD,    3, 8'h07, 16'h0000, 2'b00, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[11] = '{K_WR,    0, 210,   16'h7777, 2'b11, 0, 16'h0, 16'h0000, 16'h0000};
    tbl[12] = '{K_RD,    0, 210,   16'h0000, 2'b00, 0, 16'h0, 16'h7777, 16'h0000};
    tbl[13] = '{K_COL,   0, 8'h30, 16'hC3C3, 2'b01, 0, 16'h0, 16'h00C3, 16'h0000};
    tbl[14] = '{K_RD,    0, 8'h30, 16'h0000, 2'b00, 0, 16'h0, 16'h00C3, 16'h00C3};

    // ---- reset, then the automatic clear must last exactly DEPTH cycles ----
    idle();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    n0 = if0.init_busy ? 1 : 0;
    n1 = if1.init_busy ? 1 : 0;
    guard = 0;
    while ((if0.init_busy || if1.init_busy) && guard < 1000) begin
      cyc();
      guard++;
      if (if0.init_busy) n0++;
      if (if1.init_busy) n1++;
    end
    cmp("reset_clear_len", 0, 0, 16'(n0), 16'd256);
    cmp("reset_clear_len", 1, 0, 16'(n1), 16'd200);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      idle();
      case (tbl[i].kind)
        K_WR:  set_a(tbl[i].bank, tbl[i].addr, tbl[i].data, tbl[i].we);
        K_RD:  set_b(tbl[i].bank, tbl[i].addr);
        K_COL: begin
          set_a(tbl[i].bank, tbl[i].addr, tbl[i].data, tbl[i].we);
          set_b(tbl[i].bank, tbl[i].addr);
        end
        K_BC: begin
          set_a(0, tbl[i].addr, tbl[i].data, tbl[i].we);
          set_a(3, tbl[i].aux_addr, tbl[i].aux_data, 2'b11);
          bcast = 1'b1;
        end
        default: for (int b = 0; b < BANKS; b++) set_b(b, tbl[i].addr);
      endcase
      cyc();
      idle();
      repeat (RL - 1) cyc();
      for (int b = 0; b < BANKS; b++) begin
        if (tbl[i].kind == K_RDALL || ((tbl[i].kind == K_RD || tbl[i].kind == K_COL) && b == tbl[i].bank)) begin
          cmp("tbl_validb", 0, b, {15'h0, if0.validb[b]}, 16'h1);
          cmp("tbl_doutb", 0, b, if0.doutb[b*16 +: 16], tbl[i].exp0);
          cmp("tbl_validb", 1, b, {15'h0, if1.validb[b]}, 16'h1);
          cmp("tbl_doutb", 1, b, if1.doutb[b*16 +: 16], tbl[i].exp1);
        end
      end
    end

    // ---- 8 back-to-back port B reads on bank 2 ----
    p0 = 0; other = 0; first_p = -1; last_p = -1;
    for (int c = 0; c < 8 + RL + 2; c++) begin
      idle();
      if (c < 8) set_b(2, 8'h10);
      cyc();
      if (if0.validb[2]) begin
        p0++;
        if (first_p < 0) first_p = c;
        last_p = c;
      end
      other += int'(if0.validb[0]) + int'(if0.validb[1]) + int'(if0.validb[3]);
    end
    cmp("pipe_pulses", 0, 2, 16'(p0), 16'd8);
    cmp("pipe_span", 0, 2, 16'(last_p - first_p), 16'd7);
    cmp("pipe_other_banks", 0, 0, 16'(other), 16'd0);

    // ---- clear_req during traffic ----
    idle();
    for (int b = 0; b < BANKS; b++) set_b(b, 8'h05);
    cyc();
    idle();
    clear_req = 1'b1;
    cyc();
    p0 = if0.validb[0] ? 1 : 0;
    n0 = if0.init_busy ? 1 : 0;
    n1 = if1.init_busy ? 1 : 0;
    guard = 0;
    while ((if0.init_busy || if1.init_busy) && guard < 600) begin
      idle();
      if (if0.init_busy) enb = 4'hF;
      if (guard == 100) clear_req = 1'b1;
      cyc();
      guard++;
      if (if0.validb[0]) p0++;
      if (if0.init_busy) n0++;
      if (if1.init_busy) n1++;
    end
    cmp("clear_len", 0, 0, 16'(n0), 16'd256);
    cmp("clear_len", 1, 0, 16'(n1), 16'd200);
    cmp("clear_inflight_pulses", 0, 0, 16'(p0), 16'd1);
    idle();
    repeat (RL + 1) cyc();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 500; c++) begin
      idle();
      for (int b = 0; b < BANKS; b++) begin
        if ($urandom_range(0, 1) == 1) set_a(b, rnd_addr(), 16'($urandom), 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 1) == 1) set_b(b, rnd_addr());
      end
      bcast     = ($urandom_range(0, 7) == 0);
      clear_req = ($urandom_range(0, 299) == 0);
      cyc();
    end
    idle();
    guard = 0;
    while ((if0.init_busy || if1.init_busy) && guard < 600) begin
      cyc();
      guard++;
    end
    repeat (RL + 1) cyc();

    // ---- reset one cycle after a read: the read must never complete ----
    idle();
    for (int b = 0; b < BANKS; b++) set_b(b, 8'h05);
    cyc();
    idle();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    p0 = int'(if0.validb != 0);
    p1 = int'(if1.validb != 0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      p0 += int'(if0.validb != 0);
      p1 += int'(if1.validb != 0);
    end
    cmp("reset_discard", 0, 0, 16'(p0), 16'd0);
    cmp("reset_discard", 1, 0, 16'(p1), 16'd0);
    guard = 0;
    while ((if0.init_busy || if1.init_busy) && guard < 600) begin
      cyc();
      guard++;
    end
    cmp("final_idle", 0, 0, {15'h0, if0.init_busy}, 16'h0);
    cmp("final_idle", 1, 0, {15'h0, if1.init_busy}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
